// File: rtl/blur_strip_feeder.sv
// blur_strip_feeder: assembles 20-pixel strips for the blur controller, walks its anchor and streams the 16-pixel results.
// Optional BLUR_FEEDER_PREFETCH_EN adds a second strip buffer so the next strip loads while a result drains.
module blur_strip_feeder #(
  parameter int STEPS_X = 8,
  parameter int STEPS_Y = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic [19:0][7:0] blur_in,
  output logic             anchor_moving,
  output logic [31:0]      anchor_x,
  output logic [31:0]      anchor_y,
  input  logic             blur_final,
  input  logic [15:0][7:0] blur_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last
);
  typedef enum logic [2:0] {IDLE, FILL, ISSUE, WAIT, CAPTURE, DRAIN} state_t;
  state_t state;
  logic [1:0] obeat;
  logic [15:0][7:0] res;
  logic [31:0] tag_x, tag_y, res_x, res_y, nx, ny;
  logic acc_in, x_end, r_last;
  assign acc_in = in_valid && in_ready;
  assign x_end = anchor_x == 32'(STEPS_X - 1);
  assign r_last = res_x == 32'(STEPS_X - 1) && res_y == 32'(STEPS_Y - 1);
  assign nx = x_end ? '0 : anchor_x + 32'd1;
  assign ny = x_end ? anchor_y + 32'd1 : anchor_y;
  assign busy = state != IDLE;
  assign out_valid = state == DRAIN;
  assign out_data = out_valid ? res[{obeat, 2'b00} +: 4] : '0;
  assign out_last = out_valid && obeat == 2'd3 && r_last;
`ifdef BLUR_FEEDER_PREFETCH_EN
  logic [19:0][7:0] nxt, next_strip;
  logic [2:0] ncnt;
  logic pend, pf_issue, full_now, a_last;
  assign a_last = x_end && anchor_y == 32'(STEPS_Y - 1);
  // a strip counts as complete in the cycle its final beat is accepted
  assign full_now = ncnt == 3'd5 || (acc_in && ncnt == 3'd4);
  assign next_strip = ncnt == 3'd5 ? nxt : {in_data, nxt[15:0]};
  assign in_ready = ncnt != 3'd5 && (state == FILL || ((state == WAIT || state == CAPTURE || state == DRAIN) && !a_last));
  assign anchor_moving = state == ISSUE || (state == CAPTURE && pf_issue);
`else
  logic [2:0] fcnt;
  assign in_ready = state == FILL;
  assign anchor_moving = state == ISSUE;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      obeat <= '0;
      blur_in <= '0;
      res <= '0;
      anchor_x <= '0;
      anchor_y <= '0;
      tag_x <= '0;
      tag_y <= '0;
      res_x <= '0;
      res_y <= '0;
      done <= 1'b0;
`ifdef BLUR_FEEDER_PREFETCH_EN
      nxt <= '0;
      ncnt <= '0;
      pend <= 1'b0;
      pf_issue <= 1'b0;
`else
      fcnt <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BLUR_FEEDER_PREFETCH_EN
      if (acc_in) begin
        nxt[{ncnt, 2'b00} +: 4] <= in_data;
        ncnt <= ncnt + 3'd1;
      end
`endif
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          anchor_x <= '0;
          anchor_y <= '0;
`ifdef BLUR_FEEDER_PREFETCH_EN
          ncnt <= '0;
          pend <= 1'b0;
          pf_issue <= 1'b0;
`else
          fcnt <= '0;
`endif
        end
`ifdef BLUR_FEEDER_PREFETCH_EN
        FILL: if (full_now) begin
          blur_in <= next_strip;
          ncnt <= '0;
          state <= ISSUE;
        end
`else
        FILL: if (acc_in) begin
          blur_in[{fcnt, 2'b00} +: 4] <= in_data;
          fcnt <= fcnt == 3'd4 ? '0 : fcnt + 3'd1;
          if (fcnt == 3'd4) state <= ISSUE;
        end
`endif
        ISSUE: begin
          tag_x <= anchor_x;
          tag_y <= anchor_y;
          state <= WAIT;
        end
        WAIT: if (blur_final) begin
          state <= CAPTURE;
`ifdef BLUR_FEEDER_PREFETCH_EN
          // the next strip is presented in the capture cycle, which doubles as its issue
          pend <= 1'b0;
          pf_issue <= full_now && !a_last;
          if (full_now && !a_last) begin
            blur_in <= next_strip;
            ncnt <= '0;
            anchor_x <= nx;
            anchor_y <= ny;
          end
`endif
        end
        CAPTURE: begin
          res <= blur_out;
          res_x <= tag_x;
          res_y <= tag_y;
          obeat <= '0;
          state <= DRAIN;
`ifdef BLUR_FEEDER_PREFETCH_EN
          if (pf_issue) begin
            tag_x <= anchor_x;
            tag_y <= anchor_y;
            pend <= 1'b1;
          end
          pf_issue <= 1'b0;
`endif
        end
        DRAIN: if (out_ready) begin
          obeat <= obeat + 2'd1;
          if (obeat == 2'd3) begin
            if (r_last) begin
              done <= 1'b1;
              state <= IDLE;
            end
`ifdef BLUR_FEEDER_PREFETCH_EN
            else if (pend) state <= WAIT;
            else begin
              anchor_x <= nx;
              anchor_y <= ny;
              state <= full_now ? ISSUE : FILL;
              if (full_now) begin
                blur_in <= next_strip;
                ncnt <= '0;
              end
            end
`else
            else begin
              anchor_x <= nx;
              anchor_y <= ny;
              state <= FILL;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_strip_feeder.sv
// tb_blur_strip_feeder: directed bench with an upstream source, a blur controller model and a downstream sink.
module tb_blur_strip_feeder;
  localparam int SX = 8, SY = 4, LAT = 20, NA = SX * SY;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, blur_final = 1, out_ready = 0;
  logic busy, done, in_ready, anchor_moving, out_valid, out_last;
  logic [31:0] in_data = '0, anchor_x, anchor_y, out_data;
  logic [19:0][7:0] blur_in;
  logic [15:0][7:0] blur_out = '0;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int idx = 0, iss = 0, b = 0, ph = 0, hold = 0, raise_cyc = 0, last_cyc = 0;
  bit run = 0, up_acc = 0, fresh = 0;
  logic [31:0] rec_x = '0, rec_y = '0;

  blur_strip_feeder #(.STEPS_X(SX), .STEPS_Y(SY)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blur_in(blur_in), .anchor_moving(anchor_moving), .anchor_x(anchor_x), .anchor_y(anchor_y),
    .blur_final(blur_final), .blur_out(blur_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] strip(input int n);
    logic [159:0] s;
    for (int i = 0; i < 20; i++) s[8*i +: 8] = 8'(n * 20 + i);
    return s;
  endfunction

  function automatic logic [7:0] pat(input int n, input int i);
    return 8'(160 + n * 16 + i);
  endfunction

  function automatic logic [31:0] word(input int w);
    return {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)};
  endfunction

  function automatic logic [31:0] exp_beat(input int n);
    logic [31:0] e;
    for (int j = 0; j < 4; j++) e[8*j +: 8] = pat(n / 4, (n % 4) * 4 + j);
    return e;
  endfunction

  // environment: upstream source, controller model and downstream sink, all acting mid-cycle
  initial forever begin
    @(negedge clk);
    if (!run) begin
      in_valid = 0;
      out_ready = 0;
      up_acc = 0;
    end else begin
      if (up_acc) idx++;
      in_valid = (cyc % 5) != 0;
      in_data = word(idx);
      up_acc = in_valid && in_ready;
      if (anchor_moving) begin
        chk("issue_idle", ph, 0);
        chk("issue_ax", anchor_x, iss % SX);
        chk("issue_ay", anchor_y, iss / SX);
        chk("issue_strip", blur_in, strip(iss));
      end
      if (ph != 0) begin
        if (ph == 1) begin
          blur_final = 0;
          blur_out = {16{8'hEE}};
        end
        if (ph == LAT) begin
          blur_final = 1;
          raise_cyc = cyc;
          fresh = 1;
          chk("anchor_hold", {anchor_x, anchor_y}, {rec_x, rec_y});
        end
        if (ph == LAT + 1)
          for (int i = 0; i < 16; i++) blur_out[i] = pat(int'(rec_y) * SX + int'(rec_x), i);
        ph = (ph == LAT + 1) ? 0 : ph + 1;
      end else if (anchor_moving) begin
        rec_x = anchor_x;
        rec_y = anchor_y;
        iss++;
        ph = 1;
      end
      if (b == 14 && hold > 0) chk("stall_valid", out_valid, 1);
      if (out_valid) begin
        if (fresh) begin
          chk("final_to_valid", cyc, raise_cyc + 2);
          fresh = 0;
        end
        chk("out_data", out_data, exp_beat(b));
        chk("out_last", out_last, b == NA * 4 - 1);
        if (b == 14 && hold < 10) begin
          out_ready = 0;
          hold++;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_ax", anchor_x, 3);
        end else begin
          out_ready = 1;
          last_cyc = cyc;
          b++;
        end
      end else out_ready = 1;
    end
  end

  task automatic chk_reset(input string t);
    chk({t, "_ctl"}, {in_ready, out_valid, out_last, busy, done, anchor_moving}, 0);
    chk({t, "_out_data"}, out_data, 0);
    chk({t, "_anchor"}, {anchor_x, anchor_y}, 0);
    chk({t, "_blur_in"}, blur_in, 0);
  endtask

  task automatic begin_walk();
    idx = 0; iss = 0; b = 0; hold = 0; fresh = 0; up_acc = 0; run = 1;
    @(negedge clk); #1;
    start = 1;
    chk("start_busy0", busy, 0);
    @(negedge clk); #1;
    start = 0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy1", busy, 1);
  endtask

  task automatic walk_done();
    int t = 0;
    while (!done && t < 5000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("done_seen", done, 1);
    chk("done_timing", cyc, last_cyc + 1);
    chk("beats", b, NA * 4);
    chk("issues", iss, NA);
    chk("busy_after_done", busy, 0);
    @(negedge clk); #1;
    chk("done_pulse", done, 0);
    run = 0;
  endtask

  initial begin
    int t;
    blur_out = {16{8'hEE}};
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst0");
    rst = 0;
    begin_walk();
    walk_done();
    begin_walk();
    t = 0;
    while (b < 2 && t < 2000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("partial_reach", b, 2);
    rst = 1;
    run = 0;
    @(negedge clk); #1;
    chk_reset("rst_mid");
    rst = 0;
    ph = 0;
    blur_final = 1;
    blur_out = {16{8'hEE}};
    begin_walk();
    walk_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/blur_strip_feeder.md
# blur_strip_feeder

Source side of the blur controller interface. Pulls pixels from an upstream 32-bit stream and assembles 20-pixel strips. For each strip it drives the blur controller's strip input, pulses its start strobe and walks its anchor position. It then waits for the filter-complete flag, captures the 16 filtered pixels and streams them downstream 4 pixels per beat.

## Interface
- STEPS_X, 8: anchor_x positions per column (inner walk); anchor_x==0 is the controller's history-replicate position
- STEPS_Y, 4: anchor_y positions (outer walk)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a full walk; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last result beat is accepted
- in_valid  in  1  upstream pixel beat valid
- in_ready  out  1  feeder accepts beat
- in_data  in  32  4 pixels; [7:0] = lowest pixel index
- blur_in  out  20x8  strip to controller
- anchor_moving  out  1  one-cycle issue strobe to controller
- anchor_x  out  32  inner anchor index, zero-extended
- anchor_y  out  32  outer anchor index, zero-extended
- blur_final  in  1  controller filter-complete flag (also high while controller idle)
- blur_out  in  16x8  filtered pixels from controller
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_data  out  32  4 result pixels; [7:0] = lowest index
- out_last  out  1  final beat of final anchor

## Operation
- States: IDLE, FILL, ISSUE, WAIT, CAPTURE, DRAIN.
- IDLE -> FILL on start. Anchor counters clear to 0.
- FILL:
  - in_ready=1.
  - Beat k (0..4) writes blur_in[4k+3:4k]. Beat completes when in_valid&&in_ready.
  - After beat 4: -> ISSUE.
- ISSUE: one cycle; anchor_moving=1. blur_in and the anchor outputs are stable this cycle. The tag {anchor_x,anchor_y} is latched. -> WAIT.
- WAIT: blur_final is sampled only here. It is ignored in the ISSUE cycle because the controller is still idle. When blur_final==1: -> CAPTURE.
- CAPTURE: one cycle; latches blur_out into the 16-byte result register. The controller's last write lands at the edge ending the blur_final cycle, so capture must be one cycle later. -> DRAIN.
- DRAIN:
  - out_valid=1. Beat k (0..3) presents result[4k+3:4k].
  - Data is held until out_ready. Beat 3 accepted: advance anchor.
- Anchor advance:
  - anchor_x++. At STEPS_X-1, anchor_x wraps to 0 and anchor_y++.
  - After (STEPS_X-1, STEPS_Y-1): done pulse and -> IDLE.
  - Otherwise -> FILL.
- anchor_x/anchor_y must not change between ISSUE and the controller's blur_final; the controller reads anchor_x throughout processing.
- out_last=1 only on beat 3 of anchor (STEPS_X-1, STEPS_Y-1).
- Total results per walk: STEPS_X*STEPS_Y*4 beats.

## Timing
- Reset values:
  - anchor_moving 0, anchor_x/anchor_y 0, blur_in all 0.
  - in_ready 0, out_valid 0, out_data 0, out_last 0, busy 0, done 0.
  - State IDLE.
- Reset mid-walk: the next cycle is IDLE with all outputs at reset values, and the partial strip is discarded. The controller's own reset is handled at top level.
- start → first in_ready: 1 cycle (start cycle, then FILL).
- Last fill beat → anchor_moving: next cycle.
- blur_final (in WAIT) → CAPTURE → first out_valid: 2 cycles after blur_final.
- Zero-stall per-anchor overhead (no prefetch): 5 fill + 1 issue + controller latency + 1 capture + 4 drain cycles.
- in_ready is combinational from state only, never from in_valid. out_valid is never dropped without out_ready.

## Configuration
- BLUR_FEEDER_PREFETCH_EN defined:
  - Adds a second 20-byte strip buffer. in_ready stays asserted during WAIT/CAPTURE/DRAIN until the next strip is fully buffered.
  - The next ISSUE coincides with the CAPTURE cycle when the buffered strip is complete. blur_in and the anchor outputs switch to the next strip in that cycle.
  - The result register takes the tag latched at the previous issue.
  - DRAIN of N overlaps the controller's processing of N+1. A new CAPTURE stalls until DRAIN of the prior result completes.
- Undefined: strictly serial flow as in Operation; in_ready only in FILL.

## Test plan
- STEPS_X=2, STEPS_Y=1; start; fill beats 0x03020100..0x13121110. Expected:
  - blur_in[i]=i and one anchor_moving pulse with anchor_x=0.
  - Model blur_final after 20 cycles and blur_out[i]=0xA0+i. Beats are 0xA3A2A1A0..0xAFAEADAC, anchor_x then 1, out_last on beat 7, done 1 cycle after.
- blur_final held high through ISSUE → no CAPTURE until the model drops and re-raises blur_final; exactly one capture per issue.
- out_ready low 10 cycles on beat 2 → out_data/out_valid stable; no extra in_ready, anchor unchanged.
- Full 8x4 walk → anchor sequence (0,0),(1,0)..(7,0),(0,1)..(7,3); 128 result beats; anchor_x stable from each issue until its blur_final.
- rst asserted during DRAIN beat 1 → next cycle all outputs at reset values; new start restarts at (0,0).
- With BLUR_FEEDER_PREFETCH_EN, upstream always valid → anchor_moving coincides with CAPTURE cycle; per-anchor period = controller latency + 2.
